// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery final-subtraction slice.
//   WIDTH / LIMB / TW : modulus width, limb width, input operand width
//   NLIMB             : number of limbs covering TW (derived, not overridable)
//   limb_idx_t        : limb counter type
//   state_t           : sequencer states
package mont_pkg;

   localparam int WIDTH = 1024;
   localparam int LIMB  = 64;
   localparam int TW    = WIDTH + 4;

   function automatic int calc_nlimb(input int tw, input int limb);
      return (tw + limb - 1) / limb;
   endfunction

   localparam int NLIMB = calc_nlimb(TW, LIMB);
   localparam int IDXW  = $clog2(NLIMB);
   localparam int XW    = NLIMB * LIMB;

   typedef logic [IDXW-1:0] limb_idx_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/limb_sub.sv
// Combinational single-limb subtractor with borrow in/out.
//   a, b : limb operands
//   bin  : borrow in
//   d    : a - b - bin, modulo 2^LIMB
//   bout : borrow out (1 when a < b + bin)
module limb_sub #(
   parameter int LIMB = 64
) (
   input  logic [LIMB-1:0] a,
   input  logic [LIMB-1:0] b,
   input  logic            bin,
   output logic [LIMB-1:0] d,
   output logic            bout
);

   logic [LIMB:0] diff_ext;

   // One extra bit catches the borrow as the sign of the extended difference.
   assign diff_ext = {1'b0, a} - {1'b0, b} - {{LIMB{1'b0}}, bin};
   assign d        = diff_ext[LIMB-1:0];
   assign bout     = diff_ext[LIMB];

endmodule

// File: rtl/mont_final_sub.sv
// Word-serial conditional final subtraction: returns t mod M for t < 2M.
// One LIMB-wide borrow chain is walked across NLIMB limbs, then the result
// is chosen between t and t-M based on the final borrow.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   start  : request pulse, honoured only in IDLE
//   in_t   : value to reduce (TW bits), captured on accepted start
//   in_m   : modulus (WIDTH bits), captured on accepted start
//   busy   : high while limbs are being processed
//   done   : one-cycle pulse, result valid
//   result : reduced value, held until the next accepted start
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// SUB   | one limb of T - M - borrow per cycle
// DONE  | result presented, done pulse
module mont_final_sub
   import mont_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [TW-1:0]    in_t,
   input  logic [WIDTH-1:0] in_m,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   state_t          state;
   state_t          state_nxt;

   logic [XW-1:0]   t_reg;
   logic [XW-1:0]   m_reg;
   logic [XW-1:0]   d_reg;
   logic [XW-1:0]   d_ins;
   limb_idx_t       idx;
   logic            borrow;
   logic            last_limb;

   logic [LIMB-1:0] a_limb;
   logic [LIMB-1:0] b_limb;
   logic [LIMB-1:0] d_limb;
   logic            bout;

   // Difference bits above WIDTH only feed the chain, never the result.
   logic            unused_d_hi;

   assign a_limb    = t_reg[idx*LIMB +: LIMB];
   assign b_limb    = m_reg[idx*LIMB +: LIMB];
   assign last_limb = (idx == limb_idx_t'(NLIMB - 1));

   limb_sub #(.LIMB(LIMB)) u_limb_sub (
      .a    (a_limb),
      .b    (b_limb),
      .bin  (borrow),
      .d    (d_limb),
      .bout (bout)
   );

   // Difference register with the current limb merged in, so the final
   // selection can happen on the last SUB cycle and be valid with done.
   always_comb begin
      d_ins                    = d_reg;
      d_ins[idx*LIMB +: LIMB]  = d_limb;
   end

   assign unused_d_hi = ^d_ins[XW-1:WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SUB;
         SUB:     if (last_limb) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         SUB:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         t_reg  <= '0;
         m_reg  <= '0;
         d_reg  <= '0;
         idx    <= '0;
         borrow <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  t_reg  <= {{(XW-TW){1'b0}}, in_t};
                  m_reg  <= {{(XW-WIDTH){1'b0}}, in_m};
                  idx    <= '0;
                  borrow <= 1'b0;
               end
            end
            SUB: begin
               d_reg  <= d_ins;
               borrow <= bout;
               idx    <= last_limb ? '0 : idx + 1'b1;
               // Final borrow set means t < M: keep t unchanged.
               if (last_limb) begin
                  result <= bout ? t_reg[WIDTH-1:0] : d_ins[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mont_final_sub.sv
module tb_mont_final_sub;
   import mont_pkg::*;

   localparam int BW = XW;

   typedef struct {
      string        name;
      logic [BW-1:0] t;
      logic [BW-1:0] m;
      logic [BW-1:0] exp;
      bit            waive;
   } vec_t;

   logic             clk;
   logic             reset;
   logic             start;
   logic [TW-1:0]    in_t;
   logic [WIDTH-1:0] in_m;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   int n_checks;
   int n_pass;

   mont_final_sub dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .in_t   (in_t),
      .in_m   (in_m),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [BW-1:0] pow2(input int n);
      logic [BW-1:0] v;
      v = '0;
      v[n] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Launch a job and follow it to done. Optionally re-pulse start with other
   // operands at sample poke_at (0 = never). Returns latency and busy count.
   task automatic run_job(input logic [BW-1:0] t, input logic [BW-1:0] m,
                          input int poke_at,
                          output int lat, output int busy_cnt, output bit timed_out);
      int n;
      @(posedge clk); #1;
      start = 1'b1;
      in_t  = t[TW-1:0];
      in_m  = m[WIDTH-1:0];
      @(posedge clk); #1;
      start     = 1'b0;
      n         = 1;
      busy_cnt  = 0;
      timed_out = 1'b1;
      lat       = 0;
      while (n < 60) begin
         if (done) begin
            timed_out = 1'b0;
            lat       = n;
            break;
         end
         if (busy) busy_cnt++;
         if (poke_at != 0 && n == poke_at) begin
            start = 1'b1;
            in_t  = TW'(5);
            in_m  = WIDTH'(3);
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
   endtask

   task automatic do_vec(input vec_t v, input int poke_at);
      int lat, bc;
      bit to;
      if (!v.waive && !(v.t < (v.m << 1)))
         $error("precondition t < 2M violated in %s", v.name);
      run_job(v.t, v.m, poke_at, lat, bc, to);
      chk({v.name, " timeout"}, BW'(to), BW'(0));
      chk({v.name, " latency"}, BW'(lat), BW'(18));
      chk({v.name, " busy cycles"}, BW'(bc), BW'(17));
      chk({v.name, " result"}, BW'(result), v.exp);
   endtask

   task automatic watch_no_done(input string name, input int cycles);
      int pulses;
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      chk(name, BW'(pulses), BW'(0));
   endtask

   vec_t vecs[7];
   logic [BW-1:0] m_a;
   logic [BW-1:0] m_full;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      start    = 1'b0;
      in_t     = '0;
      in_m     = '0;

      m_a    = pow2(1023) + BW'(12345);
      m_full = pow2(1024) - BW'(1);

      vecs[0] = '{"t=m+5",        m_a + BW'(5),        m_a,            BW'(5),                                  1'b0};
      vecs[1] = '{"t=m-1",        m_a - BW'(1),        m_a,            m_a - BW'(1),                            1'b0};
      vecs[2] = '{"ripple",       pow2(1023),          pow2(64)+BW'(1), pow2(1023) - pow2(64) - BW'(1),         1'b1};
      vecs[3] = '{"t=m",          m_a,                 m_a,            BW'(0),                                  1'b0};
      vecs[4] = '{"t=0 m=1",      BW'(0),              BW'(1),         BW'(0),                                  1'b0};
      vecs[5] = '{"t=2m-1 max",   (m_full << 1) - BW'(1), m_full,      m_full - BW'(1),                         1'b0};
      vecs[6] = '{"t=5 m=3",      BW'(5),              BW'(3),         BW'(2),                                  1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk("reset busy",   BW'(busy),   BW'(0));
      chk("reset done",   BW'(done),   BW'(0));
      chk("reset result", BW'(result), BW'(0));
      reset = 1'b0;

      foreach (vecs[i]) do_vec(vecs[i], 0);

      // start pulsed mid-job with other operands must not disturb the job
      do_vec(vecs[0], 5);
      watch_no_done("no queued job", 25);
      chk("result held", BW'(result), BW'(5));
      do_vec(vecs[6], 0);

      // reset at limb 7 aborts without a done pulse
      begin
         int n;
         @(posedge clk); #1;
         start = 1'b1;
         in_t  = TW'(m_a + BW'(5));
         in_m  = WIDTH'(m_a);
         @(posedge clk); #1;
         start = 1'b0;
         for (n = 1; n < 8; n++) begin
            @(posedge clk); #1;
         end
         chk("busy at limb 7", BW'(busy), BW'(1));
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
         chk("abort busy",   BW'(busy),   BW'(0));
         chk("abort done",   BW'(done),   BW'(0));
         chk("abort result", BW'(result), BW'(0));
         watch_no_done("no done after abort", 25);
      end
      do_vec('{"after abort t=m+9", m_a + BW'(9), m_a, BW'(9), 1'b0}, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
